mux_2x1_arbiter_seq: RTL and testbench

MUX_2X1_ARBITER_SEQ -- requirements
Module: mux_2x1_arbiter_seq

---
 rtl/mux_2x1_arbiter_seq.sv | 170 +++++++++++++++++
 tb/tb_mux_2x1_arbiter_seq.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mux_2x1_arbiter_seq.sv
// Two-requester credit-gated arbiter that drives a 2x1 sequential mux.
// Round-robin choice in IDLE, burst lock up to MAX_BURST beats, downstream beat credits.
module mux_2x1_arbiter_seq #(
    parameter int COMMMAND_WIDTH = 1,
    parameter int MAX_BURST      = 4,
    parameter int CREDIT_NUM     = 8,
    parameter int CREDIT_WIDTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                i_valid,
    input  logic [1:0]                i_last,
    output logic [1:0]                o_ready,
    input  logic                      i_credit_return,
    output logic                      o_mux_en,
    output logic [COMMMAND_WIDTH-1:0] o_mux_cmd,
    output logic [1:0]                o_mux_valid,
    output logic [CREDIT_WIDTH-1:0]   o_credit_cnt,
    output logic                      o_credit_err,
    output logic                      o_busy
);

    localparam int BCW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST);
    localparam logic [BCW-1:0]            BURST_LAST  = BCW'(MAX_BURST - 1);
    localparam logic [BCW-1:0]            BEAT_ONE    = BCW'(1);
    localparam logic [BCW-1:0]            BEAT_ZERO   = BCW'(0);
    localparam logic [CREDIT_WIDTH-1:0]   CREDIT_FULL = CREDIT_WIDTH'(CREDIT_NUM);
    localparam logic [CREDIT_WIDTH-1:0]   CREDIT_ONE  = CREDIT_WIDTH'(1);
    localparam logic [CREDIT_WIDTH-1:0]   CREDIT_ZERO = CREDIT_WIDTH'(0);
    localparam logic [COMMMAND_WIDTH-1:0] CMD_LOW     = COMMMAND_WIDTH'(0);
    localparam logic [COMMMAND_WIDTH-1:0] CMD_HIGH    = COMMMAND_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOCK_LOW  = 2'd1,
        ST_LOCK_HIGH = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic                      rr_ptr_q, rr_ptr_d;
    logic [BCW-1:0]            beat_cnt_q, beat_cnt_d;
    logic [CREDIT_WIDTH-1:0]   credit_cnt_q, credit_cnt_d;
    logic                      credit_err_q, credit_err_d;
    logic                      busy_q, busy_d;

    logic [1:0]                grant_s;
    logic [1:0]                ready_s;
    logic [1:0]                beat_s;
    logic                      beat_any_s;
    logic                      beat_high_s;
    logic                      last_s;
    logic                      credit_ok_s;

    // Grant selection: round-robin tie-break in IDLE, fixed owner while locked.
    always_comb begin
        grant_s = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (i_valid == 2'b11) begin
                    grant_s = rr_ptr_q ? 2'b10 : 2'b01;
                end else begin
                    grant_s = i_valid;
                end
            end
            ST_LOCK_LOW:  grant_s = 2'b01;
            ST_LOCK_HIGH: grant_s = 2'b10;
            default:      grant_s = 2'b00;
        endcase
    end

    // Handshake and mux command for the beat happening this cycle.
    always_comb begin
        credit_ok_s = (credit_cnt_q != CREDIT_ZERO);
        if (credit_ok_s && !rst) begin
            ready_s = grant_s;
        end else begin
            ready_s = 2'b00;
        end
        beat_s      = i_valid & ready_s;
        beat_any_s  = beat_s[0] | beat_s[1];
        beat_high_s = beat_s[1];
        if (beat_high_s) begin
            last_s = i_last[1];
        end else begin
            last_s = i_last[0];
        end
    end

    // Burst state machine next-state: lock on a non-last beat, release on last or MAX_BURST.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        if (beat_any_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (last_s || (MAX_BURST == 1)) begin
                        rr_ptr_d   = ~beat_high_s;
                        beat_cnt_d = BEAT_ZERO;
                    end else begin
                        state_d    = beat_high_s ? ST_LOCK_HIGH : ST_LOCK_LOW;
                        beat_cnt_d = BEAT_ONE;
                    end
                end
                ST_LOCK_LOW, ST_LOCK_HIGH: begin
                    if (last_s || (beat_cnt_q == BURST_LAST)) begin
                        state_d    = ST_IDLE;
                        rr_ptr_d   = ~beat_high_s;
                        beat_cnt_d = BEAT_ZERO;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_ONE;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    beat_cnt_d = BEAT_ZERO;
                end
            endcase
        end else begin
            state_d    = state_q;
            beat_cnt_d = beat_cnt_q;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // Credit accounting; a return into a full counter is flagged instead of wrapping.
    always_comb begin
        credit_cnt_d = credit_cnt_q;
        credit_err_d = 1'b0;
        case ({beat_any_s, i_credit_return})
            2'b10: credit_cnt_d = credit_cnt_q - CREDIT_ONE;
            2'b01: begin
                if (credit_cnt_q == CREDIT_FULL) begin
                    credit_err_d = 1'b1;
                end else begin
                    credit_cnt_d = credit_cnt_q + CREDIT_ONE;
                end
            end
            default: credit_cnt_d = credit_cnt_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= 1'b0;
            beat_cnt_q   <= BEAT_ZERO;
            credit_cnt_q <= CREDIT_FULL;
            credit_err_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            beat_cnt_q   <= beat_cnt_d;
            credit_cnt_q <= credit_cnt_d;
            credit_err_q <= credit_err_d;
            busy_q       <= busy_d;
        end
    end

    assign o_ready      = ready_s;
    assign o_mux_valid  = beat_s;
    assign o_mux_en     = beat_any_s;
    assign o_mux_cmd    = beat_high_s ? CMD_HIGH : CMD_LOW;
    assign o_credit_cnt = credit_cnt_q;
    assign o_credit_err = credit_err_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_mux_2x1_arbiter_seq.sv
// Table-driven bench for mux_2x1_arbiter_seq with a scoreboard queue of expected records,
// followed by a hand-written credit-exhaustion sequence.
module tb_mux_2x1_arbiter_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] i_valid;
    logic [1:0] i_last;
    logic [1:0] o_ready;
    logic       i_credit_return;
    logic       o_mux_en;
    logic [0:0] o_mux_cmd;
    logic [1:0] o_mux_valid;
    logic [3:0] o_credit_cnt;
    logic       o_credit_err;
    logic       o_busy;

    int checks   = 0;
    int failures = 0;

    mux_2x1_arbiter_seq dut (
        .clk             (clk),
        .rst             (rst),
        .i_valid         (i_valid),
        .i_last          (i_last),
        .o_ready         (o_ready),
        .i_credit_return (i_credit_return),
        .o_mux_en        (o_mux_en),
        .o_mux_cmd       (o_mux_cmd),
        .o_mux_valid     (o_mux_valid),
        .o_credit_cnt    (o_credit_cnt),
        .o_credit_err    (o_credit_err),
        .o_busy          (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] valid;
        logic [1:0] last;
        logic       ret;
        logic [1:0] ready;
        logic [1:0] mvalid;
        logic       cmd;
        logic [3:0] cnt;
        logic       busy;
        logic       err;
    } vec_t;

    vec_t tbl[$];
    vec_t sb_q[$];

    function automatic vec_t mk(logic r, logic [1:0] v, logic [1:0] l, logic rt,
                                logic [1:0] rdy, logic [1:0] mv, logic c,
                                int n, logic b, logic e);
        vec_t t;
        t.rst = r;  t.valid = v; t.last = l;  t.ret = rt;
        t.ready = rdy; t.mvalid = mv; t.cmd = c;
        t.cnt = 4'(n); t.busy = b; t.err = e;
        return t;
    endfunction

    task automatic chk(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%0h expected=%0h", name, row, act, exp);
        end
    endtask

    initial begin
        vec_t e;
        int   n;
        bit   stalled;

        rst = 1'b1; i_valid = 2'b00; i_last = 2'b00; i_credit_return = 1'b0;

        //          rst  valid  last   ret   ready  mvalid cmd  cnt busy err
        tbl.push_back(mk(1'b1, 2'b11, 2'b11, 1'b1, 2'b00, 2'b00, 1'b0, 8, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 2'b11, 2'b11, 1'b0, 2'b01, 2'b01, 1'b0, 8, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 2'b11, 2'b11, 1'b0, 2'b10, 2'b10, 1'b1, 7, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 2'b11, 2'b11, 1'b0, 2'b01, 2'b01, 1'b0, 6, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 2'b11, 2'b11, 1'b0, 2'b10, 2'b10, 1'b1, 5, 1'b0, 1'b0));
        for (int k = 4; k < 8; k++)
            tbl.push_back(mk(1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, k, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 8, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 8, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 8, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 2'b01, 2'b01, 1'b1, 2'b01, 2'b01, 1'b0, 8, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 8, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 2'b10, 2'b10, 1'b0, 2'b10, 2'b10, 1'b1, 8, 1'b0, 1'b0));
        // low burst of non-last beats: forced release after four, then high wins
        tbl.push_back(mk(1'b0, 2'b11, 2'b00, 1'b0, 2'b01, 2'b01, 1'b0, 7, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 2'b11, 2'b00, 1'b0, 2'b01, 2'b01, 1'b0, 6, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 2'b11, 2'b00, 1'b0, 2'b01, 2'b01, 1'b0, 5, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 2'b11, 2'b00, 1'b0, 2'b01, 2'b01, 1'b0, 4, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 2'b11, 2'b00, 1'b0, 2'b10, 2'b10, 1'b1, 3, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 2'b11, 2'b00, 1'b0, 2'b10, 2'b10, 1'b1, 2, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 2'b01, 2'b00, 1'b0, 2'b10, 2'b00, 1'b0, 1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 2'b11, 2'b11, 1'b0, 2'b01, 2'b01, 1'b0, 8, 1'b0, 1'b0));
        // credit exhaustion on single-beat low requests
        tbl.push_back(mk(1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 7, 1'b0, 1'b0));
        for (int k = 8; k > 0; k--)
            tbl.push_back(mk(1'b0, 2'b01, 2'b01, 1'b0, 2'b01, 2'b01, 1'b0, k, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 2'b01, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 2'b01, 2'b01, 1'b1, 2'b00, 2'b00, 1'b0, 0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 2'b01, 2'b01, 1'b0, 2'b01, 2'b01, 1'b0, 1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 2'b01, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 0, 1'b0, 1'b0));
        // zero credits inside a high lock: stall without leaving the lock
        tbl.push_back(mk(1'b0, 2'b11, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 2'b11, 2'b00, 1'b0, 2'b10, 2'b10, 1'b1, 1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 2'b11, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 2'b11, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 2'b11, 2'b10, 1'b0, 2'b10, 2'b10, 1'b1, 1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 0, 1'b0, 1'b0));

        repeat (2) @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].rst; i_valid = tbl[i].valid; i_last = tbl[i].last;
            i_credit_return = tbl[i].ret;
            sb_q.push_back(tbl[i]);
            #2;
            e = sb_q.pop_front();
            chk("ready",      i, 8'(o_ready),      8'(e.ready));
            chk("mux_valid",  i, 8'(o_mux_valid),  8'(e.mvalid));
            chk("mux_en",     i, 8'(o_mux_en),     8'(e.mvalid != 2'b00));
            chk("mux_cmd",    i, 8'(o_mux_cmd),    8'(e.cmd));
            chk("credit_cnt", i, 8'(o_credit_cnt), 8'(e.cnt));
            chk("busy",       i, 8'(o_busy),       8'(e.busy));
            chk("credit_err", i, 8'(o_credit_err), 8'(e.err));
        end

        // Hand sequence: from reset, count transfers until credits run out (bounded).
        @(negedge clk);
        rst = 1'b1; i_valid = 2'b00; i_last = 2'b00; i_credit_return = 1'b0;
        @(negedge clk);
        rst = 1'b0; i_valid = 2'b01; i_last = 2'b01;
        n = 0;
        stalled = 1'b0;
        for (int c = 0; c < 20 && !stalled; c++) begin
            #2;
            if (o_ready == 2'b00) stalled = 1'b1;
            else if (o_mux_valid == 2'b01) n++;
            @(negedge clk);
        end
        chk("stall_reached", 100, 8'(stalled), 8'd1);
        chk("beats_to_stall", 100, n[7:0], 8'd8);
        i_credit_return = 1'b1;
        #2;
        chk("ready_while_return", 101, 8'(o_ready), 8'd0);
        @(negedge clk);
        i_credit_return = 1'b0;
        #2;
        chk("beat_after_return", 102, 8'(o_mux_valid), 8'd1);
        @(negedge clk);
        #2;
        chk("stall_again", 103, 8'(o_ready), 8'd0);
        @(negedge clk);
        i_valid = 2'b00; i_last = 2'b00;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
